// File: rtl/sobel_frame_writer.sv
// Packs the binary Sobel edge stream into words and writes one frame per
// vsync period into a frame-buffer RAM, flagging raster-geometry errors.
module sobel_frame_writer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sobel,
  input  logic                  sobel_valid,
  input  logic                  sobel_hsync,
  input  logic                  sobel_vsync,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [WORD_WIDTH-1:0] wr_data,
  output logic                  frame_busy,
  output logic                  frame_done,
  output logic                  frame_err
);

  localparam int NWORDS = IMG_WIDTH * IMG_HEIGHT / WORD_WIDTH;
  localparam int CW     = $clog2(WORD_WIDTH);
  localparam int PW     = $clog2(IMG_WIDTH + 2);
  localparam int LW     = $clog2(IMG_HEIGHT + 2);
  localparam int AW1    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    FLUSH
  } state_t;

  state_t                state;
  logic                  hs_q;
  logic                  vs_q;
  logic [CW-1:0]         cnt;
  logic [WORD_WIDTH-1:0] acc;
  logic [PW-1:0]         pix_cnt;
  logic [LW-1:0]         line_cnt;

  logic                  hs_fall;
  logic                  vs_fall;
  logic                  vs_rise;
  logic                  take;
  logic                  line_end;
  logic                  word_full;
  logic                  do_wr;
  logic [AW1-1:0]        next_addr;
  logic                  ovf;
  logic [WORD_WIDTH-1:0] full_word;
  logic [WORD_WIDTH-1:0] pad_word;

  // Sync edges, pixel acceptance and the write-address lookahead.
  always_comb begin
    hs_fall   = hs_q & ~sobel_hsync;
    vs_fall   = vs_q & ~sobel_vsync;
    vs_rise   = sobel_vsync & ~vs_q;
    take      = (state == ACTIVE) & sobel_valid
              & sobel_hsync & sobel_vsync;
    line_end  = (state == ACTIVE) & (hs_fall | vs_fall);
    word_full = take && (cnt == CW'(WORD_WIDTH - 1));
    do_wr     = word_full | (line_end && (cnt != '0));
    next_addr = {1'b0, wr_addr} + AW1'(wr_en);
    ovf       = next_addr >= AW1'(NWORDS);
  end

  // Completed word, and a partial word padded white above the count.
  always_comb begin
    full_word = acc;
    full_word[WORD_WIDTH-1] = sobel;
    pad_word = '1;
    for (int k = 0; k < WORD_WIDTH; k++) begin
      if (CW'(k) < cnt) pad_word[k] = acc[k];
    end
  end

  // Registered sync copies; vsync starts high so a frame already in
  // progress at reset release is skipped until its next rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q <= 1'b0;
      vs_q <= 1'b1;
    end else begin
      hs_q <= sobel_hsync;
      vs_q <= sobel_vsync;
    end
  end

  // Frame FSM with packing, line/frame checks and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      acc        <= '0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      wr_addr    <= next_addr[ADDR_WIDTH-1:0];
      case (state)
        IDLE: begin
          if (vs_rise) begin
            wr_addr    <= '0;
            cnt        <= '0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            frame_err  <= 1'b0;
            frame_busy <= 1'b1;
            state      <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (take) begin
            if (word_full) begin
              cnt <= '0;
            end else begin
              acc[cnt] <= sobel;
              cnt      <= cnt + 1'b1;
            end
            if (pix_cnt != PW'(IMG_WIDTH + 1))
              pix_cnt <= pix_cnt + 1'b1;
          end
          if (do_wr) begin
            if (ovf) begin
              frame_err <= 1'b1;
            end else begin
              wr_en   <= 1'b1;
              wr_data <= word_full ? full_word : pad_word;
            end
          end
          if (line_end) begin
            cnt     <= '0;
            pix_cnt <= '0;
            if (pix_cnt != '0) begin
              if (line_cnt != LW'(IMG_HEIGHT + 1))
                line_cnt <= line_cnt + 1'b1;
              if (pix_cnt != PW'(IMG_WIDTH))
                frame_err <= 1'b1;
            end
          end
          if (vs_fall) begin
            frame_busy <= 1'b0;
            state      <= FLUSH;
          end
        end
        FLUSH: begin
          frame_done <= 1'b1;
          if (line_cnt != LW'(IMG_HEIGHT))
            frame_err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_frame_writer.sv
// Bench for sobel_frame_writer on a 32x4 raster with 16-bit words:
// frame-level write model, per-cycle compare process, directed frames.
module tb_sobel_frame_writer;

  logic        clk;
  logic        reset_n;
  logic        sobel;
  logic        sobel_valid;
  logic        sobel_hsync;
  logic        sobel_vsync;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_busy;
  logic        frame_done;
  logic        frame_err;

  sobel_frame_writer #(
    .IMG_WIDTH (32),
    .IMG_HEIGHT(4),
    .WORD_WIDTH(16),
    .ADDR_WIDTH(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sobel      (sobel),
    .sobel_valid(sobel_valid),
    .sobel_hsync(sobel_hsync),
    .sobel_vsync(sobel_vsync),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_busy (frame_busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  typedef struct {
    int          a;
    logic [15:0] d;
  } wr_t;

  wr_t  exp_q[$];
  logic exp_err;
  int   exp_done;
  int   got_done;
  int   tests;
  int   fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic pix(input int mode, input int i);
    case (mode)
      0:       return 1'b1;
      1:       return (i % 2) != 0;
      default: return 1'b0;
    endcase
  endfunction

  // Expected writes of one frame: lines chopped into 16-pixel words,
  // short tails padded white, nothing at or beyond word 8.
  task automatic model_frame(input int nlines, input int mode,
                             input int sidx, input int slen);
    int addr;
    int lines;
    logic [15:0] d;
    addr = 0;
    lines = 0;
    exp_err = 1'b0;
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = (l == sidx) ? slen : 32;
      if (len > 0) lines++;
      if (len > 0 && len != 32) exp_err = 1'b1;
      for (int w = 0; w * 16 < len; w++) begin
        for (int k = 0; k < 16; k++)
          d[k] = (w * 16 + k < len) ? pix(mode, w * 16 + k) : 1'b1;
        if (addr >= 8) exp_err = 1'b1;
        else exp_q.push_back('{a: addr, d: d});
        addr++;
      end
    end
    if (lines != 4) exp_err = 1'b1;
    exp_done++;
  endtask

  // Compare every write and every frame_done against the model.
  always @(negedge clk) begin
    if (reset_n) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("spurious_wr", 32'(wr_en), 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), e.a);
          check("wr_data", 32'(wr_data), 32'(e.d));
        end
      end
      if (frame_done) begin
        got_done++;
        check("done_err", 32'(frame_err), 32'(exp_err));
      end
    end
  end

  task automatic step(input logic v, input logic h,
                      input logic vs, input logic p);
    @(posedge clk);
    #1;
    sobel_valid = v;
    sobel_hsync = h;
    sobel_vsync = vs;
    sobel = p;
  endtask

  task automatic drive_frame(input int nlines, input int mode,
                             input int gap, input int sidx,
                             input int slen, input bit chk);
    repeat (3) step(0, 0, 1, 0);
    @(negedge clk);
    check("busy_on", 32'(frame_busy), 1);
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = (l == sidx) ? slen : 32;
      for (int i = 0; i < len; i++) begin
        for (int g = 1; g < gap; g++) step(0, 1, 1, 0);
        step(1, 1, 1, pix(mode, i));
        if (chk && l == 0 && i == 15) begin
          @(negedge clk);
          check("lat_early", 32'(wr_en), 0);
        end
        if (chk && l == 0 && i == 16) begin
          @(negedge clk);
          check("lat_wr_en", 32'(wr_en), 1);
          check("lat_data", 32'(wr_data), 32'h0000_AAAA);
        end
      end
      repeat (3) step(0, 0, 1, 0);
    end
    step(0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("done_early", 32'(frame_done), 0);
    @(negedge clk);
    check("done_pulse", 32'(frame_done), 1);
    @(negedge clk);
    check("done_width", 32'(frame_done), 0);
    check("busy_off", 32'(frame_busy), 0);
    check("writes_left", exp_q.size(), 0);
    check("done_count", got_done, exp_done);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr_en"}, 32'(wr_en), 0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 0);
    check({tag, "_wr_data"}, 32'(wr_data), 0);
    check({tag, "_busy"}, 32'(frame_busy), 0);
    check({tag, "_done"}, 32'(frame_done), 0);
    check({tag, "_err"}, 32'(frame_err), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    exp_done = 0;
    got_done = 0;
    exp_err = 1'b0;
    reset_n = 1'b0;
    sobel = 1'b0;
    sobel_valid = 1'b0;
    sobel_hsync = 1'b0;
    sobel_vsync = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    reset_n = 1'b1;

    // Nominal frame, all white.
    model_frame(4, 0, -1, 0);
    check("m_nom_n", exp_q.size(), 8);
    check("m_nom_a7", exp_q[7].a, 7);
    check("m_nom_d7", 32'(exp_q[7].d), 32'hFFFF);
    check("m_nom_err", 32'(exp_err), 0);
    drive_frame(4, 0, 1, -1, 0, 1'b0);
    check("nom_err", 32'(frame_err), 0);

    // Alternating pixels, with write latency pinned.
    model_frame(4, 1, -1, 0);
    check("m_alt_d0", 32'(exp_q[0].d), 32'hAAAA);
    drive_frame(4, 1, 1, -1, 0, 1'b1);

    // Sparse valid: same words, slower.
    model_frame(4, 0, -1, 0);
    drive_frame(4, 0, 3, -1, 0, 1'b0);

    // Short second line of 20 black pixels.
    model_frame(4, 2, 1, 20);
    check("m_short_d3", 32'(exp_q[3].d), 32'hFFF0);
    check("m_short_err", 32'(exp_err), 1);
    drive_frame(4, 2, 1, 1, 20, 1'b0);
    check("short_err", 32'(frame_err), 1);

    // Extra fifth line overflows the buffer.
    model_frame(5, 0, -1, 0);
    check("m_ovf_n", exp_q.size(), 8);
    drive_frame(5, 0, 1, -1, 0, 1'b0);
    check("addr_hold", 32'(wr_addr), 8);
    check("ovf_err", 32'(frame_err), 1);

    // Reset mid-line, vsync still high at release.
    exp_q.delete();
    exp_q.push_back('{a: 0, d: 16'hAAAA});
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 1, (i % 2) != 0);
    @(negedge clk);
    check("pre_rst_wr", exp_q.size(), 0);
    reset_n = 1'b0;
    #1;
    check_zero("mid_rst");
    sobel_valid = 1'b0;
    sobel_hsync = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) step(0, 0, 1, 0);
    @(negedge clk);
    check("vs_held", 32'(frame_busy), 0);
    repeat (3) step(0, 0, 0, 0);
    @(negedge clk);
    check("no_done", got_done, exp_done);

    // Clean frame after reset starts at address 0.
    model_frame(4, 1, -1, 0);
    drive_frame(4, 1, 1, -1, 0, 1'b0);
    check("post_rst_err", 32'(frame_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
